// File: rtl/alu_seq.sv
// alu_seq: registered, width-parametrised ALU with a start/busy/done handshake.
// Single-cycle ops complete on the accepting edge; multiply and divide iterate
// over W steps when ALU_MULDIV_EN is defined. With ALU_MULDIV_EN undefined,
// 1110/1111 return rslt=0, sc_o=1 and busy is tied low.
//
// state | meaning
// IDLE  | ready; a start is accepted here only
// ITER  | shift-add / restoring-divide steps in progress
// FIN   | iterations complete; result and flags register on the next edge
module alu_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [3:0]   alu_cmd,
    input  logic [W-1:0] inA,
    input  logic [W-1:0] inB,
    input  logic         sc_i,
    output logic [W-1:0] rslt,
    output logic         sc_o,
    output logic         zero,
    output logic         pari,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

    state_t       state;
    logic [W-1:0] sc_r;
    logic         sc_c;
    logic [W:0]   wide;
    logic [W-1:0] nxt_r;
    logic         nxt_c;

    // Single-cycle result, taken straight from the inputs at the accepting edge
    always_comb begin
        sc_r = '0;
        sc_c = 1'b0;
        wide = '0;
        case (alu_cmd)
            4'b0000: {sc_c, sc_r} = {1'b0, inA} + {1'b0, inB};
            4'b0001: begin
                sc_r = inA - inB;
                sc_c = (inA < inB);
            end
            4'b0010: {sc_c, sc_r} = {1'b0, inA} + {1'b0, inB} + {{W{1'b0}}, sc_i};
            4'b0011: sc_r = inA;
            4'b0100: sc_r = inB;
            4'b0101: sc_r = ~(inA | inB);
            4'b0110: sc_r = inA ^ inB;
            4'b0111: sc_r = inA & inB;
            4'b1000: sc_r = inA | inB;
            // The extra bit above/below A catches the last bit shifted out;
            // amounts beyond W shift everything out and leave both at zero.
            4'b1001: begin
                wide = {1'b0, inA} << inB;
                {sc_c, sc_r} = wide;
            end
            4'b1010: begin
                wide = {inA, 1'b0} >> inB;
                sc_r = wide[W:1];
                sc_c = wide[0];
            end
            4'b1011: sc_r = {{(W-1){1'b0}}, (inA == inB)};
            4'b1100: sc_r = {{(W-1){1'b0}}, (inA < inB)};
            4'b1101: sc_r = {{(W-1){1'b0}}, ^inB};
`ifdef ALU_MULDIV_EN
            // Only the divide-by-zero case of 1111 reaches the single-cycle path
            4'b1111: begin
                sc_r = '1;
                sc_c = 1'b1;
            end
`else
            4'b1110, 4'b1111: begin
                sc_r = '0;
                sc_c = 1'b1;
            end
`endif
            default: begin
                sc_r = '0;
                sc_c = 1'b0;
            end
        endcase
    end

`ifdef ALU_MULDIV_EN
    localparam int CW = $clog2(W + 1);

    logic [2*W-1:0] p;
    logic [2*W-1:0] p_src;
    logic [2*W-1:0] p_nxt;
    logic [W-1:0]   opd;
    logic [W-1:0]   opd_src;
    logic           is_div;
    logic           div_src;
    logic [CW-1:0]  cnt;
    logic           busy_q;
    logic           is_multi;
    logic [W:0]     sum;
    logic [W:0]     rem_t;
    logic           ge;
    logic [W-1:0]   rem_new;

    assign busy     = busy_q;
    assign is_multi = (alu_cmd == 4'b1110) || ((alu_cmd == 4'b1111) && (inB != '0));

    // One multiply/divide step; the first step runs on the accepting edge
    // straight from the inputs, the rest from the held registers.
    // p holds {acc, multiplier} for mul and {remainder, dividend/quotient} for div.
    always_comb begin
        p_src   = (state == IDLE) ? {{W{1'b0}}, (alu_cmd[0] ? inA : inB)} : p;
        opd_src = (state == IDLE) ? (alu_cmd[0] ? inB : inA) : opd;
        div_src = (state == IDLE) ? alu_cmd[0] : is_div;
        sum     = {1'b0, p_src[2*W-1:W]} + {1'b0, (p_src[0] ? opd_src : {W{1'b0}})};
        rem_t   = {p_src[2*W-1:W], p_src[W-1]};
        ge      = (rem_t >= {1'b0, opd_src});
        rem_new = ge ? W'(rem_t - {1'b0, opd_src}) : rem_t[W-1:0];
        if (div_src)
            p_nxt = {rem_new, p_src[W-2:0], ge};
        else
            p_nxt = {sum, p_src[W-1:1]};
    end

    // Pick the value that lands in rslt/sc_o: iterative result in FIN, else single-cycle
    always_comb begin
        nxt_r = sc_r;
        nxt_c = sc_c;
        if (state == FIN) begin
            nxt_r = p[W-1:0];
            nxt_c = is_div ? 1'b0 : (|p[2*W-1:W]);
        end
    end
`else
    assign busy = 1'b0;

    // Without the iterative datapath every op is single-cycle
    always_comb begin
        nxt_r = sc_r;
        nxt_c = sc_c;
    end
`endif

    // Sequencer with registered result, flags and handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            rslt  <= '0;
            sc_o  <= 1'b0;
            zero  <= 1'b1;
            pari  <= 1'b0;
            done  <= 1'b0;
`ifdef ALU_MULDIV_EN
            busy_q <= 1'b0;
            p      <= '0;
            opd    <= '0;
            is_div <= 1'b0;
            cnt    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
`ifdef ALU_MULDIV_EN
                        if (is_multi) begin
                            state  <= ITER;
                            busy_q <= 1'b1;
                            p      <= p_nxt;
                            opd    <= opd_src;
                            is_div <= div_src;
                            cnt    <= CW'(1);
                        end else
`endif
                        begin
                            rslt <= nxt_r;
                            sc_o <= nxt_c;
                            zero <= ~|nxt_r;
                            pari <= ^nxt_r;
                            done <= 1'b1;
                        end
                    end
                end
`ifdef ALU_MULDIV_EN
                ITER: begin
                    p   <= p_nxt;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(W - 1))
                        state <= FIN;
                end
                FIN: begin
                    rslt   <= nxt_r;
                    sc_o   <= nxt_c;
                    zero   <= ~|nxt_r;
                    pari   <= ^nxt_r;
                    done   <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (W=8). Stimulus pushes expected responses;
// an independent monitor pops and checks on every done pulse.
module tb_alu_seq;
    localparam int W = 8;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [3:0]   alu_cmd;
    logic [W-1:0] inA;
    logic [W-1:0] inB;
    logic         sc_i;
    logic [W-1:0] rslt;
    logic         sc_o;
    logic         zero;
    logic         pari;
    logic         busy;
    logic         done;

    alu_seq #(.W(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .alu_cmd(alu_cmd),
        .inA(inA), .inB(inB), .sc_i(sc_i), .rslt(rslt), .sc_o(sc_o),
        .zero(zero), .pari(pari), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        int           at;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int total = 0;
    int bad   = 0;

`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rslt", 32'(rslt), 32'(e.r));
                chk("sc_o", 32'(sc_o), 32'(e.c));
                chk("zero", 32'(zero), 32'(e.r == '0));
                chk("pari", 32'(pari), 32'(^e.r));
                chk("done_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic issue(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic [W-1:0] er, input logic ec, input bit multi);
        exp_t x;
        @(negedge clk);
        alu_cmd = cmd; inA = a; inB = b; sc_i = ci; start = 1'b1;
        x.r = er; x.c = ec; x.at = cyc + 1 + (multi ? W : 0);
        sb.push_back(x);
        @(posedge clk);
        #1;
        start = 1'b0;
        alu_cmd = 4'($urandom); inA = W'($urandom); inB = W'($urandom); sc_i = 1'($urandom);
    endtask

    task automatic pulse_ignored(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        alu_cmd = 4'b1110; inA = a; inB = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int nb);
        bit seen;
        seen = 1'b0;
        nb = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [3:0]   cmd;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] r;
        logic         c;
    } vec_t;

    vec_t vecs[$] = '{
        '{4'b0000, 8'hFF, 8'h01, 1'b1, 8'h00, 1'b1},
        '{4'b0010, 8'h10, 8'h01, 1'b1, 8'h12, 1'b0},
        '{4'b0001, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1},
        '{4'b0011, 8'h3C, 8'hC3, 1'b0, 8'h3C, 1'b0},
        '{4'b0100, 8'h3C, 8'hC3, 1'b0, 8'hC3, 1'b0},
        '{4'b0101, 8'h0F, 8'h30, 1'b0, 8'hC0, 1'b0},
        '{4'b0110, 8'hA5, 8'hFF, 1'b0, 8'h5A, 1'b0},
        '{4'b0111, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0},
        '{4'b1000, 8'h81, 8'h18, 1'b0, 8'h99, 1'b0},
        '{4'b1001, 8'h81, 8'h01, 1'b0, 8'h02, 1'b1},
        '{4'b1001, 8'h81, 8'h09, 1'b0, 8'h00, 1'b0},
        '{4'b1001, 8'h81, 8'h08, 1'b0, 8'h00, 1'b1},
        '{4'b1001, 8'h81, 8'h00, 1'b0, 8'h81, 1'b0},
        '{4'b1010, 8'h81, 8'h08, 1'b0, 8'h00, 1'b1},
        '{4'b1010, 8'h81, 8'h01, 1'b0, 8'h40, 1'b1},
        '{4'b1010, 8'h81, 8'h00, 1'b0, 8'h81, 1'b0},
        '{4'b1010, 8'h81, 8'hC8, 1'b0, 8'h00, 1'b0},
        '{4'b1011, 8'h33, 8'h33, 1'b0, 8'h01, 1'b0},
        '{4'b1011, 8'h33, 8'h34, 1'b0, 8'h00, 1'b0},
        '{4'b1100, 8'h02, 8'h03, 1'b0, 8'h01, 1'b0},
        '{4'b1100, 8'hFF, 8'h03, 1'b0, 8'h00, 1'b0},
        '{4'b1101, 8'h00, 8'h07, 1'b0, 8'h01, 1'b0},
        '{4'b1101, 8'hFF, 8'h03, 1'b0, 8'h00, 1'b0}
    };

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        reset_n = 1'b0; start = 1'b0; alu_cmd = '0; inA = '0; inB = '0; sc_i = 1'b0;
        #12;
        chk("reset_rslt", 32'(rslt), 32'h0);
        chk("reset_sc_o", 32'(sc_o), 32'h0);
        chk("reset_zero", 32'(zero), 32'h1);
        chk("reset_pari", 32'(pari), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Back-to-back single-cycle ops, one start per cycle
        foreach (vecs[i])
            issue(vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].r, vecs[i].c, 1'b0);
        repeat (3) @(negedge clk);

        // Multiply / divide
        issue(4'b1110, 8'd200, 8'd3, 1'b0, MD ? 8'h58 : 8'h00, 1'b1, MD);
        wait_done(nb);
        chk("mul_busy_cycles", 32'(nb), MD ? 32'd8 : 32'd0);
        issue(4'b1110, 8'd15, 8'd17, 1'b0, MD ? 8'hFF : 8'h00, MD ? 1'b0 : 1'b1, MD);
        wait_done(nb);
        issue(4'b1111, 8'd100, 8'd7, 1'b0, MD ? 8'h0E : 8'h00, MD ? 1'b0 : 1'b1, MD);
        wait_done(nb);
        chk("div_busy_cycles", 32'(nb), MD ? 32'd8 : 32'd0);
        issue(4'b1111, 8'd5, 8'd0, 1'b0, MD ? 8'hFF : 8'h00, 1'b1, 1'b0);
        wait_done(nb);
        chk("div0_busy_cycles", 32'(nb), 32'd0);

`ifdef ALU_MULDIV_EN
        // Starts during an in-flight mul are dropped
        issue(4'b1110, 8'd200, 8'd3, 1'b0, 8'h58, 1'b1, 1'b1);
        pulse_ignored(8'd15, 8'd17);
        @(negedge clk);
        pulse_ignored(8'd9, 8'd9);
        wait_done(nb);
        repeat (12) @(negedge clk);

        // Reset aborts a mul at cycle 4 without a clock edge; rslt is 0x58 beforehand
        issue(4'b1110, 8'd15, 8'd17, 1'b0, 8'hFF, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        chk("pre_reset_busy", 32'(busy), 32'h1);
`else
        issue(4'b0110, 8'hA5, 8'hFF, 1'b0, 8'h5A, 1'b0, 1'b0);
        wait_done(nb);
        @(posedge clk);
        #2;
`endif
        reset_n = 1'b0;
        sb.delete();
        #1;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_rslt", 32'(rslt), 32'h0);
        chk("abort_zero", 32'(zero), 32'h1);
        chk("abort_sc_o", 32'(sc_o), 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        issue(4'b0001, 8'd3, 8'd5, 1'b0, 8'hFE, 1'b1, 1'b0);
        wait_done(nb);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the single-cycle 8-bit ALU.
- Width is generic. Adds carry-in add, carry/borrow out, clamped shifts with shift-out bit, iterative unsigned multiply and divide, and a start/busy/done handshake.
- Sits in the execute stage. The controller stalls the PC while busy is high.
- Result and flags (sc_o, zero, pari) are registered and held until the next completed operation.

Parameters:
- W, 8: operand and result width. Must be ≥ 2.
- CW, $clog2(W+1): iteration counter width. Derived; not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  operation request, sampled on a rising edge.
- alu_cmd  in  4  operation select.
- inA  in  W  operand A (unsigned).
- inB  in  W  operand B (unsigned).
- sc_i  in  1  carry-in bit.
- rslt  out  W  registered result.
- sc_o  out  1  registered carry/shift/status-out bit.
- zero  out  1  registered; equals (rslt == 0).
- pari  out  1  registered; equals ^rslt.
- busy  out  1  high while a multi-cycle operation iterates.
- done  out  1  one-cycle pulse when rslt and flags update.

Behaviour:
- Reset (asynchronous, reset_n low): rslt=0, sc_o=0, zero=1, pari=0, busy=0, done=0. Counter and internal operand registers clear. Any in-flight operation is aborted with no done pulse.
- States: IDLE, ITER, FIN.
- Accept rule: start is accepted only when state==IDLE. A start while busy or in FIN is ignored; it is not queued. alu_cmd, inA, inB and sc_i are captured at acceptance, so later input changes have no effect.
- Single-cycle ops: result registered on the accepting edge. done=1 for the following cycle. busy stays 0. State stays IDLE, so back-to-back starts every cycle are legal.
- Multi-cycle ops (1110 mul, 1111 divu with inB≠0):
  - IDLE→ITER on accept; busy=1.
  - W iterations in ITER.
  - ITER→FIN when the counter reaches W.
  - FIN registers the result, drives busy=0 and done=1 the next cycle, then returns to IDLE.
  - done is asserted exactly W+1 cycles after the accepting edge.
- zero and pari always reflect the newly registered rslt, in the same cycle.
- Opcodes (all arithmetic modulo 2^W):
  - 0000 add: rslt=A+B; sc_o=carry out.
  - 0001 sub: rslt=A−B; sc_o=borrow (A<B).
  - 0010 adc: rslt=A+B+sc_i; sc_o=carry out.
  - 0011 pass A.
  - 0100 pass B.
  - 0101 nor: bitwise ~(A|B).
  - 0110 xor.
  - 0111 and.
  - 1000 or.
  - 1001 sll: shift amount = B, full width.
    - B=0: rslt=A, sc_o=0.
    - 1≤B≤W: rslt=A<<B, sc_o=A[W−B].
    - B>W: rslt=0, sc_o=0.
  - 1010 srl: same rules, with sc_o=A[B−1].
  - 1011 eq: rslt={0…,A==B}; sc_o=0.
  - 1100 ltu: rslt={0…,A<B}; sc_o=0.
  - 1101 rxor: rslt={0…,^B}; sc_o=0.
  - 1110 mul: shift-add over 2W bits; rslt=low W bits; sc_o=|high W bits (overflow).
  - 1111 divu: restoring division; rslt=quotient; sc_o=0.
    - inB=0: divide-by-zero is treated as single-cycle, with rslt=all ones and sc_o=1.
- Simultaneous events: done and a new accepted start in the same cycle is legal. The new result overwrites on the next edge.

Optional Feature:
- Macro: ALU_MULDIV_EN.
- Defined: 1110/1111 behave as specified, with the iterative datapath and ITER/FIN states.
- Undefined: no multiply/divide logic is built. 1110/1111 complete as single-cycle ops with rslt=0 and sc_o=1 (illegal-op flag). busy is tied 0.

Test Plan (W=8):
- add 0xFF+0x01, sc_i=x → one cycle later done=1, rslt=0x00, sc_o=1, zero=1, pari=0. Then adc 0x10+0x01 with sc_i=1 → rslt=0x12, sc_o=0, pari=0.
- sll 0x81 by B=1 → rslt=0x02, sc_o=1. sll by B=9 → rslt=0x00, sc_o=0, zero=1. srl 0x81 by B=8 → rslt=0x00, sc_o=1.
- mul 200×3 → busy high 8 cycles, done exactly 9 cycles after the accepting edge, rslt=0x58, sc_o=1. Then 15×17 → rslt=0xFF, sc_o=0, pari=0.
- divu 100/7 → done at cycle 9, rslt=0x0E, sc_o=0. divu 5/0 → done at cycle 1, busy never high, rslt=0xFF, sc_o=1.
- start pulsed again at cycles 3 and 5 of a mul, with different operands → ignored; only one done; result from the original operands.
- reset_n low at cycle 4 of a mul → busy=0, done=0, rslt=0, zero=1 immediately with no clock edge. After release, sub 3−5 → rslt=0xFE, sc_o=1.
